issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, 8, number of queue entries (2..16).
REQ-002 SHALL have parameter PREG_W, 6, physical register tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port disp_valid  input  1  dispatch request this cycle.
REQ-006 SHALL have port disp_pkt  input  disp_packet_t  dispatched instruction (dst/src1/src2 preg, imm_val, pc, instr_valid).
REQ-007 SHALL have port disp_src1_rdy  input  1  src1 operand already produced at dispatch.
REQ-008 SHALL have port disp_src2_rdy  input  1  src2 operand already produced at dispatch.
REQ-009 SHALL have port disp_ready  output  1  queue accepts a dispatch this cycle.
REQ-010 SHALL have port wb_valid  input  1  wakeup broadcast valid.
REQ-011 SHALL have port wb_preg  input  PREG_W  physical register being written.
REQ-012 SHALL have port flush  input  1  discard all queued entries.
REQ-013 SHALL have port fire_valid  output  1  sched_pkt valid to register read.
REQ-014 SHALL have port sched_pkt  output  disp_packet_t  selected instruction to register read.
REQ-015 SHALL have port occupancy  output  $clog2(DEPTH+1)  valid entry count.

Function
REQ-016 Queue SHALL be collapsing: entry 0 oldest; valid entries contiguous from index 0.
REQ-017 disp_ready SHALL equal (occupancy < DEPTH), independent of issue in the same cycle.
REQ-018 disp_valid && disp_ready SHALL write the packet at index occupancy-minus-removed (post-collapse tail) with src ready bits captured.
REQ-019 An entry SHALL be ready when both src ready bits set; dispatch-time ready bit SHALL be set if disp_srcN_rdy or (wb_valid && wb_preg == srcN_preg) in that cycle.
REQ-020 Every cycle with wb_valid, each valid entry SHALL set any src ready bit whose preg equals wb_preg.
REQ-021 Select SHALL pick the lowest-index ready entry; at most one issue per cycle.
REQ-022 Selected entry SHALL drive sched_pkt and fire_valid=1 registered on the next posedge (one-cycle select latency); no selection -> fire_valid=0, sched_pkt holds last value.
REQ-023 Selected entry SHALL be removed in the same edge; entries above shift down one index.
REQ-024 occupancy SHALL update as occupancy + accepted_dispatch - issued, never exceeding DEPTH or wrapping below 0.
REQ-025 Simultaneous issue and dispatch at occupancy==DEPTH-1 or less SHALL both complete in one cycle; at DEPTH, dispatch SHALL be refused even if issuing.
REQ-026 flush SHALL clear all valid bits and fire_valid on the next edge; dispatch and issue in that cycle SHALL be dropped; flush has priority over all.
REQ-027 wb_preg equal to 0 SHALL still wake matching entries (no special-casing of preg 0).

Reset
REQ-028 rst SHALL clear all entry valid bits, occupancy=0, fire_valid=0, sched_pkt='0; disp_ready=1 the cycle after reset deasserts.
REQ-029 rst asserted mid-operation SHALL override flush, dispatch, wakeup and issue in that cycle.

Configuration
REQ-030 Macro SCHED_SAME_CYCLE_WAKEUP_EN defined: entries woken by wb in cycle N SHALL be selectable in cycle N (wakeup feeds select combinationally).
REQ-031 Macro SCHED_SAME_CYCLE_WAKEUP_EN undefined: wakeup SHALL only update ready bits; woken entry selectable no earlier than cycle N+1.

Verification
REQ-032 Reset, then dispatch pc=0x100 with both rdy=1 -> fire_valid=1, sched_pkt.pc=0x100 one cycle later, occupancy back to 0.
REQ-033 Dispatch A (src1=5, not rdy) then B (ready) -> B fires first; wb_preg=5 -> A fires next (cycle N with macro, N+1 without).
REQ-034 Fill 8 non-ready entries -> disp_ready=0, occupancy=8; extra disp_valid ignored; wb wakes entry 3 -> entry 3 issues, disp_ready=1 next cycle.
REQ-035 Dispatch with src2=9 while wb_valid,wb_preg=9 same cycle -> entry captured ready, issues next cycle.
REQ-036 Occupancy 4 with ready entries, assert flush with disp_valid -> next cycle occupancy=0, fire_valid=0, dispatched packet absent.
REQ-037 Two ready entries at index 1 and 2, issue index 1 -> former index 2 now index 1, issues following cycle in order.

Source files
------------

// File: rtl/issue_scheduler.sv
// issue_scheduler -- collapsing out-of-order issue queue with wakeup/select.
//
// Entry 0 always holds the oldest instruction and valid entries are
// contiguous from index 0. Each cycle the lowest-index entry whose source
// operands are both ready is selected. It is presented on sched_pkt with
// fire_valid one posedge later and removed on that same edge, and entries
// above it slide down by one index. A dispatch accepted in the same cycle is
// written at the post-collapse tail.
//
// Optional build macro:
//   SCHED_SAME_CYCLE_WAKEUP_EN  defined   -> a wakeup broadcast in cycle N makes
//                                            the woken entry selectable in cycle N.
//                               undefined -> wakeup only updates ready bits; the
//                                            entry is selectable from cycle N+1.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   disp_valid/disp_pkt        dispatch request and instruction packet
//   disp_src1_rdy/src2_rdy     source operands already produced at dispatch
//   disp_ready                 queue has room (occupancy < DEPTH)
//   wb_valid/wb_preg           writeback wakeup broadcast
//   flush                      drop every queued entry and any in-flight issue
//   fire_valid/sched_pkt       registered select result to register read
//   occupancy                  number of valid entries

package issue_scheduler_pkg;
    localparam int SCHED_PREG_W = 6;

    typedef struct packed {
        logic [SCHED_PREG_W-1:0] dst_preg;
        logic [SCHED_PREG_W-1:0] src1_preg;
        logic [SCHED_PREG_W-1:0] src2_preg;
        logic [31:0]             imm_val;
        logic [31:0]             pc;
        logic                    instr_valid;
    } disp_packet_t;
endpackage

module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH  = 8,
    // Must match the preg width carried in disp_packet_t.
    parameter int PREG_W = SCHED_PREG_W,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    input  disp_packet_t      disp_pkt,
    input  logic              disp_src1_rdy,
    input  logic              disp_src2_rdy,
    output logic              disp_ready,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_preg,
    input  logic              flush,
    output logic              fire_valid,
    output disp_packet_t      sched_pkt,
    output logic [OCC_W-1:0]  occupancy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] r1_q, r1_d;
    logic [DEPTH-1:0] r2_q, r2_d;
    disp_packet_t     ent_q [DEPTH];
    disp_packet_t     ent_d [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             fire_valid_q, fire_valid_d;
    disp_packet_t     sched_pkt_q, sched_pkt_d;

    // ------------------------------------------------------------------
    // Combinational wakeup / select / collapse / dispatch
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] r1_w, r2_w, sel_rdy;
    logic [IDX_W-1:0] sel_idx;
    logic             issue;
    disp_packet_t     sel_pkt;
    logic [OCC_W-1:0] tail;
    logic             disp_acc;
    logic             disp_r1, disp_r2;

    // Extended views with an always-empty slot at DEPTH so the shift
    // source index i+1 is in range for the top entry.
    logic [DEPTH:0]   v_ext, r1_ext, r2_ext;
    disp_packet_t     e_ext [DEPTH+1];

    assign disp_ready = (occ_q < OCC_W'(DEPTH));
    assign disp_acc   = disp_valid && disp_ready;
    assign tail       = occ_q - OCC_W'(issue);
    assign disp_r1    = disp_src1_rdy || (wb_valid && (disp_pkt.src1_preg == wb_preg));
    assign disp_r2    = disp_src2_rdy || (wb_valid && (disp_pkt.src2_preg == wb_preg));

    always_comb begin
        r1_w    = '0;
        r2_w    = '0;
        sel_rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            r1_w[i] = r1_q[i] || (wb_valid && (ent_q[i].src1_preg == wb_preg));
            r2_w[i] = r2_q[i] || (wb_valid && (ent_q[i].src2_preg == wb_preg));
`ifdef SCHED_SAME_CYCLE_WAKEUP_EN
            sel_rdy[i] = valid_q[i] && r1_w[i] && r2_w[i];
`else
            sel_rdy[i] = valid_q[i] && r1_q[i] && r2_q[i];
`endif
        end
    end

    // Priority pick: scan from the top so the lowest ready index wins.
    always_comb begin
        sel_idx = '0;
        sel_pkt = '0;
        issue   = |sel_rdy;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sel_rdy[i]) begin
                sel_idx = IDX_W'(i);
                sel_pkt = ent_q[i];
            end
        end
    end

    always_comb begin
        v_ext  = '0;
        r1_ext = '0;
        r2_ext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_ext[i]  = valid_q[i];
            r1_ext[i] = r1_w[i];
            r2_ext[i] = r2_w[i];
            e_ext[i]  = ent_q[i];
        end
        e_ext[DEPTH] = '0;
    end

    always_comb begin
        valid_d      = '0;
        r1_d         = '0;
        r2_d         = '0;
        occ_d        = occ_q;
        fire_valid_d = issue;
        sched_pkt_d  = issue ? sel_pkt : sched_pkt_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end

        // Collapse: everything at or above the issued slot moves down one.
        // Wakeup results are folded in so no broadcast is lost in transit.
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && (IDX_W'(i) >= sel_idx)) begin
                valid_d[i] = v_ext[i+1];
                r1_d[i]    = r1_ext[i+1];
                r2_d[i]    = r2_ext[i+1];
                ent_d[i]   = e_ext[i+1];
            end else begin
                valid_d[i] = v_ext[i];
                r1_d[i]    = r1_ext[i];
                r2_d[i]    = r2_ext[i];
                ent_d[i]   = e_ext[i];
            end
        end

        // Dispatch lands at the post-collapse tail.
        if (disp_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (OCC_W'(i) == tail) begin
                    valid_d[i] = 1'b1;
                    r1_d[i]    = disp_r1;
                    r2_d[i]    = disp_r2;
                    ent_d[i]   = disp_pkt;
                end
            end
        end

        occ_d = occ_q + OCC_W'(disp_acc) - OCC_W'(issue);

        // Flush drops the queue, the dispatch and the issue of this cycle;
        // sched_pkt keeps its last value.
        if (flush) begin
            valid_d      = '0;
            r1_d         = '0;
            r2_d         = '0;
            occ_d        = '0;
            fire_valid_d = 1'b0;
            sched_pkt_d  = sched_pkt_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            occ_q        <= '0;
            fire_valid_q <= 1'b0;
            sched_pkt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            occ_q        <= occ_d;
            fire_valid_q <= fire_valid_d;
            sched_pkt_q  <= sched_pkt_d;
        end
    end

    // Payload needs no reset: it is only observed behind valid_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    assign fire_valid = fire_valid_q;
    assign sched_pkt  = sched_pkt_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    localparam int DEPTH  = 8;
    localparam int PREG_W = 6;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_valid;
    disp_packet_t      disp_pkt;
    logic              disp_src1_rdy;
    logic              disp_src2_rdy;
    logic              disp_ready;
    logic              wb_valid;
    logic [PREG_W-1:0] wb_preg;
    logic              flush;
    logic              fire_valid;
    disp_packet_t      sched_pkt;
    logic [OCC_W-1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    issue_scheduler #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .disp_valid    (disp_valid),
        .disp_pkt      (disp_pkt),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_ready    (disp_ready),
        .wb_valid      (wb_valid),
        .wb_preg       (wb_preg),
        .flush         (flush),
        .fire_valid    (fire_valid),
        .sched_pkt     (sched_pkt),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then clear one-shot stimulus away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        disp_valid    = 1'b0;
        disp_src1_rdy = 1'b0;
        disp_src2_rdy = 1'b0;
        wb_valid      = 1'b0;
        wb_preg       = '0;
        flush         = 1'b0;
    endtask

    task automatic disp(input logic [31:0] pc, input logic [5:0] s1, input logic r1,
                        input logic [5:0] s2, input logic r2);
        disp_valid        = 1'b1;
        disp_pkt          = '0;
        disp_pkt.pc       = pc;
        disp_pkt.src1_preg = s1;
        disp_pkt.src2_preg = s2;
        disp_pkt.dst_preg = 6'd63;
        disp_pkt.instr_valid = 1'b1;
        disp_src1_rdy     = r1;
        disp_src2_rdy     = r2;
    endtask

    task automatic wake(input logic [5:0] p);
        wb_valid = 1'b1;
        wb_preg  = p;
    endtask

    // After the edge carrying a wakeup: without same-cycle wakeup the
    // woken entry fires one edge later, so check the gap and step again.
    task automatic wake_settle(input string tag);
`ifndef SCHED_SAME_CYCLE_WAKEUP_EN
        chk({tag, "_gap_fire"}, 32'(fire_valid), 32'd0);
        tick();
`endif
    endtask

    initial begin
        rst = 1'b1;
        disp_valid = 1'b0; disp_pkt = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
        wb_valid = 1'b0; wb_preg = '0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_occ",   32'(occupancy),  32'd0);
        chk("rst_fire",  32'(fire_valid), 32'd0);
        chk("rst_pc",    sched_pkt.pc,    32'd0);
        chk("rst_ready", 32'(disp_ready), 32'd1);

        // Single ready dispatch
        disp(32'h100, 6'd1, 1'b1, 6'd2, 1'b1);
        tick();
        chk("d1_occ",  32'(occupancy),  32'd1);
        chk("d1_fire", 32'(fire_valid), 32'd0);
        tick();
        chk("d1_fire2", 32'(fire_valid), 32'd1);
        chk("d1_pc",    sched_pkt.pc,    32'h100);
        chk("d1_occ2",  32'(occupancy),  32'd0);
        tick();
        chk("d1_idle_fire", 32'(fire_valid), 32'd0);
        chk("d1_hold_pc",   sched_pkt.pc,    32'h100);

        // Younger ready B bypasses older blocked A
        disp(32'h200, 6'd5, 1'b0, 6'd6, 1'b1);
        tick();
        disp(32'h210, 6'd7, 1'b1, 6'd8, 1'b1);
        tick();
        chk("ab_occ", 32'(occupancy), 32'd2);
        tick();
        chk("ab_b_fire", 32'(fire_valid), 32'd1);
        chk("ab_b_pc",   sched_pkt.pc,    32'h210);
        chk("ab_occ1",   32'(occupancy),  32'd1);
        wake(6'd5);
        tick();
        wake_settle("ab");
        chk("ab_a_fire", 32'(fire_valid), 32'd1);
        chk("ab_a_pc",   sched_pkt.pc,    32'h200);
        chk("ab_occ0",   32'(occupancy),  32'd0);

        // Fill to DEPTH with blocked entries
        for (int i = 0; i < DEPTH; i++) begin
            disp(32'h300 + 32'(i * 4), 6'(10 + i), 1'b0, 6'd0, 1'b1);
            tick();
        end
        chk("full_occ",   32'(occupancy),  32'd8);
        chk("full_ready", 32'(disp_ready), 32'd0);
        disp(32'h3F0, 6'd1, 1'b1, 6'd1, 1'b1);
        tick();
        chk("full_drop_occ",  32'(occupancy),  32'd8);
        chk("full_drop_fire", 32'(fire_valid), 32'd0);
        wake(6'd13);
        tick();
        wake_settle("full");
        chk("full_e3_fire",  32'(fire_valid), 32'd1);
        chk("full_e3_pc",    sched_pkt.pc,    32'h30C);
        chk("full_e3_occ",   32'(occupancy),  32'd7);
        chk("full_e3_ready", 32'(disp_ready), 32'd1);
        // Dispatched-while-full packet must never surface
        tick();
        chk("full_no_extra", 32'(fire_valid), 32'd0);
        flush = 1'b1;
        tick();
        chk("fl0_occ", 32'(occupancy), 32'd0);

        // Dispatch-cycle wakeup on src2
        disp(32'h400, 6'd3, 1'b1, 6'd9, 1'b0);
        wake(6'd9);
        tick();
        chk("dw_occ",  32'(occupancy),  32'd1);
        tick();
        chk("dw_fire", 32'(fire_valid), 32'd1);
        chk("dw_pc",   sched_pkt.pc,    32'h400);
        chk("dw_occ0", 32'(occupancy),  32'd0);

        // Issue and dispatch in the same cycle
        disp(32'h500, 6'd1, 1'b1, 6'd1, 1'b1);
        tick();
        disp(32'h504, 6'd1, 1'b1, 6'd1, 1'b1);
        tick();
        chk("sim_pc0", sched_pkt.pc,   32'h500);
        chk("sim_occ", 32'(occupancy), 32'd1);
        tick();
        chk("sim_pc1",  sched_pkt.pc,    32'h504);
        chk("sim_fire", 32'(fire_valid), 32'd1);
        chk("sim_occ0", 32'(occupancy),  32'd0);

        // Flush beats dispatch, wakeup and issue
        for (int i = 0; i < 4; i++) begin
            disp(32'h600 + 32'(i * 4), 6'd1, 1'b1, 6'd20, 1'b0);
            tick();
        end
        chk("fl_occ4", 32'(occupancy), 32'd4);
        flush = 1'b1;
        wake(6'd20);
        disp(32'h6F0, 6'd1, 1'b1, 6'd1, 1'b1);
        tick();
        chk("fl_occ",  32'(occupancy),  32'd0);
        chk("fl_fire", 32'(fire_valid), 32'd0);
        tick();
        tick();
        chk("fl_absent_fire", 32'(fire_valid), 32'd0);
        chk("fl_absent_occ",  32'(occupancy),  32'd0);

        // Collapse keeps age order after a middle issue
        disp(32'h700, 6'd30, 1'b0, 6'd1, 1'b1);
        tick();
        disp(32'h704, 6'd1, 1'b1, 6'd1, 1'b1);
        tick();
        disp(32'h708, 6'd1, 1'b1, 6'd1, 1'b1);
        tick();
        chk("col_pc1",  sched_pkt.pc,   32'h704);
        chk("col_occ2", 32'(occupancy), 32'd2);
        tick();
        chk("col_pc2",  sched_pkt.pc,   32'h708);
        chk("col_occ1", 32'(occupancy), 32'd1);
        tick();
        chk("col_idle", 32'(fire_valid), 32'd0);
        wake(6'd30);
        tick();
        wake_settle("col");
        chk("col_pc0",  sched_pkt.pc,   32'h700);
        chk("col_occ0", 32'(occupancy), 32'd0);

        // preg 0 is an ordinary tag
        disp(32'h800, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        tick();
        chk("p0_blocked", 32'(fire_valid), 32'd0);
        wake(6'd0);
        tick();
        wake_settle("p0");
        chk("p0_fire", 32'(fire_valid), 32'd1);
        chk("p0_pc",   sched_pkt.pc,    32'h800);

        // Reset mid-operation overrides everything
        disp(32'h880, 6'd1, 1'b1, 6'd1, 1'b1);
        tick();
        chk("mr_occ1", 32'(occupancy), 32'd1);
        rst = 1'b1;
        disp(32'h900, 6'd1, 1'b1, 6'd1, 1'b1);
        wake(6'd1);
        tick();
        chk("mr_occ",  32'(occupancy),  32'd0);
        chk("mr_fire", 32'(fire_valid), 32'd0);
        chk("mr_pc",   sched_pkt.pc,    32'd0);
        rst = 1'b0;
        tick();
        chk("mr_ready", 32'(disp_ready), 32'd1);
        chk("mr_idle",  32'(fire_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
